// File: rtl/song_pkg.sv
// Shared types, constants and helpers for the song-table sequencer.
// The ROM word layout is {duration[15:8], note[7:0]}.
package song_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

   localparam int HP_W = 22;
   localparam logic [7:0] REST_NOTE = 8'd0;
   localparam logic [7:0] END_DUR   = 8'd0;

   // Half-periods (50 MHz clocks) for notes 0..11; higher octaves are right shifts.
   localparam logic [HP_W-1:0] BASE_HALF_PERIOD [12] = '{
      22'd3057805, 22'd2886184, 22'd2724195, 22'd2571298,
      22'd2426982, 22'd2290766, 22'd2162195, 22'd2040840,
      22'd1926297, 22'd1818182, 22'd1716135, 22'd1619816
   };

   function automatic logic [7:0] word_dur(input logic [15:0] word);
      return word[15:8];
   endfunction

   function automatic logic [7:0] word_note(input logic [15:0] word);
      return word[7:0];
   endfunction

   function automatic logic [HP_W-1:0] note_half_period(input logic [7:0] note,
                                                        input int unsigned shift);
      logic [3:0] semi;
      logic [3:0] oct;
      semi = 4'(note % 8'd12);
      oct  = 4'(note / 8'd12);
      return (BASE_HALF_PERIOD[semi] >> oct) >> shift;
   endfunction

endpackage

// File: rtl/song_player_tone_gen.sv
// Square-wave generator: toggles every half_period clocks while enabled,
// otherwise drives 0. A zero half-period means silence.
module tone_gen
   import song_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            enable,
   input  logic [HP_W-1:0] half_period,
   output logic            tone
);

   logic [HP_W-1:0] cnt_reg;
   logic            tone_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         tone_reg <= 1'b0;
      end else if (clear) begin
         cnt_reg  <= '0;
         tone_reg <= 1'b0;
      end else if (enable && half_period != '0) begin
         if (cnt_reg >= half_period - 1'b1) begin
            cnt_reg  <= '0;
            tone_reg <= ~tone_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         tone_reg <= 1'b0;
      end
   end

   assign tone = tone_reg;

endmodule

// File: rtl/song_player.sv
// Walks a song ROM from START_ADDR to END_ADDR, holding each entry for
// dur*TICK_CYCLES clocks (tone, then a silent gap) and driving a square wave.
module song_player
   import song_pkg::*;
#(
   parameter int unsigned START_ADDR  = 14,
   parameter int unsigned END_ADDR    = 270,
   parameter int unsigned TICK_CYCLES = 6_250_000,
   parameter int unsigned GAP_CYCLES  = 250_000,
   parameter int unsigned PITCH_SHIFT = 0
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   input  logic [15:0] rom_data,
   output logic [9:0]  rom_addr,
   output logic        tone,
   output logic        busy,
   output logic        note_strobe,
   output logic [7:0]  cur_note,
   output logic        done
);

   localparam logic [9:0]  START_A = 10'(START_ADDR);
   localparam logic [9:0]  END_A   = 10'(END_ADDR);
   localparam logic [31:0] TICK_W  = 32'(TICK_CYCLES);
   localparam logic [31:0] GAP_W   = 32'(GAP_CYCLES);

   state_t          state_reg, state_next;
   logic [9:0]      addr_reg, addr_next;
   logic [31:0]     cnt_reg, cnt_next;
   logic [7:0]      note_reg, note_next;
   logic            strobe_reg, strobe_next;
   logic            done_reg, done_next;
   logic [7:0]      dur;
   logic [31:0]     play_len;
   logic            tone_clear;
   logic            tone_enable;
   logic [HP_W-1:0] hp;

   assign dur      = word_dur(rom_data);
   assign play_len = 32'(dur) * TICK_W - GAP_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         addr_reg   <= START_A;
         cnt_reg    <= '0;
         note_reg   <= '0;
         strobe_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         cnt_reg    <= cnt_next;
         note_reg   <= note_next;
         strobe_reg <= strobe_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      cnt_next    = cnt_reg;
      note_next   = note_reg;
      strobe_next = 1'b0;
      done_next   = 1'b0;
      tone_clear  = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = FETCH;
               addr_next  = START_A;
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            tone_clear = 1'b1;
            if (dur == END_DUR) begin
               if (loop) begin
                  addr_next  = START_A;
                  state_next = FETCH;
               end else begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end else begin
               note_next   = word_note(rom_data);
               strobe_next = 1'b1;
               cnt_next    = play_len;
               state_next  = PLAY;
            end
         end
         PLAY: begin
            if (cnt_reg <= 32'd1) begin
               cnt_next   = GAP_W;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg - 32'd1;
            end
         end
         GAP: begin
            if (cnt_reg > 32'd1) begin
               cnt_next = cnt_reg - 32'd1;
            end else if (addr_reg != END_A) begin
               addr_next  = addr_reg + 10'd1;
               state_next = FETCH;
            end else if (loop) begin
               addr_next  = START_A;
               state_next = FETCH;
            end else begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort overrides everything decided above.
      if (stop) begin
         state_next  = IDLE;
         addr_next   = addr_reg;
         cnt_next    = cnt_reg;
         note_next   = note_reg;
         strobe_next = 1'b0;
         done_next   = 1'b0;
         tone_clear  = 1'b0;
      end
   end

   // Enabling only while PLAY continues makes the registered tone read 0 in GAP/IDLE.
   assign tone_enable = (state_reg == PLAY) && (state_next == PLAY);
   assign hp = (note_reg == REST_NOTE) ? '0 : note_half_period(note_reg, PITCH_SHIFT);

   tone_gen u_tone_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (tone_clear),
      .enable      (tone_enable),
      .half_period (hp),
      .tone        (tone)
   );

   assign rom_addr    = addr_reg;
   assign busy        = (state_reg == FETCH) || (state_reg == LOAD) ||
                        (state_reg == PLAY)  || (state_reg == GAP);
   assign note_strobe = strobe_reg;
   assign cur_note    = note_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_song_player.sv
// Randomized bench for song_player: an entry-level model expands each ROM song
// into an expected per-cycle trace, compared against the DUT every clock.
module tb_song_player;

   localparam int START = 2;
   localparam int END_A = 5;
   localparam int TICK  = 8;
   localparam int GAP   = 2;
   localparam int SHIFT = 14;
   localparam int MAXC  = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [15:0] rom_data;
   logic [9:0]  rom_addr;
   logic        tone;
   logic        busy;
   logic        note_strobe;
   logic [7:0]  cur_note;
   logic        done;

   logic [15:0] rom [1024];
   logic [21:0] exp_vec [MAXC];
   int          exp_len;
   int          last_note = 0;
   int          total = 0;
   int          bad = 0;

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   song_player #(
      .START_ADDR  (START),
      .END_ADDR    (END_A),
      .TICK_CYCLES (TICK),
      .GAP_CYCLES  (GAP),
      .PITCH_SHIFT (SHIFT)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .loop        (loop),
      .rom_data    (rom_data),
      .rom_addr    (rom_addr),
      .tone        (tone),
      .busy        (busy),
      .note_strobe (note_strobe),
      .cur_note    (cur_note),
      .done        (done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // Half-period from the musical definition: note 9 anchors the table, semitones
   // scale by 2^(1/12), octaves halve it, and the speed-up shift applies last.
   function automatic int ref_hp(input int n);
      real base;
      int  b;
      if (n == 0) return 0;
      base = 1818182.0 * $pow(2.0, (9.0 - real'(n % 12)) / 12.0);
      b = $rtoi(base + 0.5);
      return (b >> (n / 12)) >> SHIFT;
   endfunction

   task automatic push(input int b, input int t, input int s, input int d,
                       input int n, input int a);
      if (exp_len < MAXC) begin
         exp_vec[exp_len] = {1'(b), 1'(t), 1'(s), 1'(d), 8'(n), 10'(a)};
         exp_len++;
      end
   endtask

   // Cycle 0 is the first clock after start is sampled.
   task automatic build_model(input bit lp, input int stop_at);
      int addr, dur, nt, hp, len, note_cur;
      bit fin;
      exp_len  = 0;
      addr     = START;
      note_cur = last_note;
      fin      = 1'b0;
      while (!fin && exp_len < MAXC - 8) begin
         push(1, 0, 0, 0, note_cur, addr);
         push(1, 0, 0, 0, note_cur, addr);
         dur = int'(rom[addr][15:8]);
         nt  = int'(rom[addr][7:0]);
         if (dur != 0) begin
            hp  = ref_hp(nt);
            len = dur * TICK - GAP;
            for (int j = 0; j < len; j++)
               push(1, (hp > 0) ? ((j / hp) % 2) : 0, (j == 0) ? 1 : 0, 0, nt, addr);
            note_cur = nt;
            for (int j = 0; j < GAP; j++) push(1, 0, 0, 0, nt, addr);
         end
         if (dur == 0 || addr == END_A) begin
            if (lp) addr = START;
            else begin
               push(0, 0, 0, 1, note_cur, addr);
               fin = 1'b1;
            end
         end else begin
            addr++;
         end
      end
      for (int j = 0; j < 4; j++) push(0, 0, 0, 0, note_cur, addr);
      if (stop_at >= 0 && stop_at + 5 <= exp_len) begin
         for (int j = stop_at + 1; j <= stop_at + 4; j++)
            exp_vec[j] = {4'b0000, exp_vec[stop_at][17:0]};
         exp_len = stop_at + 5;
      end
      last_note = int'(exp_vec[exp_len-1][17:10]);
   endtask

   task automatic run_song(input string name, input bit lp, input int stop_at,
                           input int restart_at, output int busy_seen);
      int strobes, dones, e_busy, e_str, e_done, max_addr;
      build_model(lp, stop_at);
      busy_seen = 0; strobes = 0; dones = 0; e_busy = 0; e_str = 0; e_done = 0; max_addr = 0;
      loop = lp;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < exp_len; c++) begin
         check($sformatf("%s cyc%0d {busy,tone,strobe,done,note,addr}", name, c),
               {busy, tone, note_strobe, done, cur_note, rom_addr}, exp_vec[c]);
         busy_seen += int'(busy);
         strobes   += int'(note_strobe);
         dones     += int'(done);
         e_busy    += int'(exp_vec[c][21]);
         e_str     += int'(exp_vec[c][19]);
         e_done    += int'(exp_vec[c][18]);
         if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
         stop  = (c == stop_at);
         start = (c == restart_at);
         @(negedge clk);
      end
      stop  = 1'b0;
      start = 1'b0;
      loop  = 1'b0;
      check({name, " busy_cycles"}, busy_seen, e_busy);
      check({name, " strobes"}, strobes, e_str);
      check({name, " done_pulses"}, dones, e_done);
      check({name, " addr_not_past_end"}, (max_addr <= END_A), 1);
      $display("song %s: loop=%0d cycles=%0d busy=%0d strobes=%0d done=%0d",
               name, lp, exp_len, busy_seen, strobes, dones);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " rom_addr"}, rom_addr, START);
      check({tag, " tone"}, tone, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " note_strobe"}, note_strobe, 0);
      check({tag, " cur_note"}, cur_note, 0);
      check({tag, " done"}, done, 0);
   endtask

   task automatic fill_random(input bit allow_marker);
      int d;
      for (int a = START; a <= END_A + 1; a++) begin
         d = (allow_marker && $urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
         rom[a] = {8'(d), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(40, 127))};
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int bs;
      for (int a = 0; a < 1024; a++) rom[a] = 16'h0000;

      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // A440 entry then a two-unit rest, then an end marker.
      rom[2] = {8'd1, 8'd69};
      rom[3] = {8'd2, 8'd0};
      rom[4] = {8'd0, 8'd0};
      run_song("directed", 1'b0, -1, -1, bs);
      check("directed busy_len", bs, 2 + 8 + 2 + 16 + 2);

      rom[2] = {8'd0, 8'd55};
      run_song("end_marker", 1'b0, -1, -1, bs);
      check("end_marker busy_len", bs, 2);

      // Every entry playable, so the walk must stop at END_A.
      for (int a = START; a <= END_A + 1; a++)
         rom[a] = {8'($urandom_range(1, 2)), 8'($urandom_range(48, 100))};
      run_song("to_end", 1'b0, -1, -1, bs);

      for (int k = 0; k < 6; k++) begin
         fill_random(1'b1);
         run_song($sformatf("rand%0d", k), 1'b0, -1, -1, bs);
      end

      fill_random(1'b0);
      rom[START] = {8'd1, 8'd72};
      run_song("loop_stop", 1'b1, 140 + int'($urandom_range(0, 40)), -1, bs);

      rom[2] = {8'd2, 8'd81};
      rom[3] = {8'd1, 8'd64};
      run_song("stop_play", 1'b0, 2 + 5, -1, bs);

      fill_random(1'b1);
      rom[START] = {8'd2, 8'd69};
      run_song("start_busy", 1'b0, -1, 5, bs);

      // Asynchronous reset in the first GAP cycle of a dur=2 entry.
      rom[2] = {8'd2, 8'd70};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2 + 2 * TICK - GAP) @(negedge clk);
      check("gap busy", busy, 1);
      check("gap tone", tone, 0);
      rst_n = 1'b0;
      #1 check_reset("reset_mid_gap");
      @(negedge clk);
      rst_n = 1'b1;
      last_note = 0;
      $display("song reset_mid_gap: outputs returned to reset values");

      rom[2] = {8'd1, 8'd69};
      rom[3] = {8'd2, 8'd0};
      rom[4] = {8'd0, 8'd0};
      run_song("after_reset", 1'b0, -1, -1, bs);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
